bsg_mem_byte_write_coalescer: RTL and testbench

Initiator for the byte-masked write port of a 1r1w synchronous memory. Accepts a stream of partial (byte-masked) stores over valid/ready, merges consecutive stores to the same word address in a single-entry buffer, and issues one masked write (`w_v_o`/`w_mask_o`/`w_addr_o`/`w_data_o`) per coalesced word. It sits between a store-producing client (e.g. a core's store path) and a byte-mask-write RAM, and cuts RAM write activity for byte/halfword store bursts.

---
 rtl/bsg_mem_byte_write_coalescer.sv | 128 ++++++++++++
 tb/tb_bsg_mem_byte_write_coalescer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_byte_write_coalescer.sv
// Purpose: merges consecutive byte-masked stores to one word address and issues one masked RAM write per word.
// Latency: a full word is written the cycle after it completes; a partial word is written after timeout_p idle cycles, on flush_i, or when a store arrives for another address.
// Backpressure: ready_o drops only while a full, timeout or flush_i write is draining; a store to a new address is taken in the same cycle the old word is written.
module bsg_mem_byte_write_coalescer #(
    parameter int width_p   = 64,
    parameter int els_p     = 512,
    parameter int timeout_p = 8,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp = width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     v_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [mask_width_lp-1:0] mask_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    input  logic                     flush_i,

    output logic                     w_v_o,
    output logic [mask_width_lp-1:0] w_mask_o,
    output logic [addr_width_lp-1:0] w_addr_o,
    output logic [width_p-1:0]       w_data_o,

    output logic                     pending_o,
    output logic [addr_width_lp-1:0] pending_addr_o
);

    localparam int timer_width_lp = $clog2(timeout_p + 1);
    localparam logic [timer_width_lp-1:0] timeout_lp = timer_width_lp'(timeout_p);

    typedef enum logic {
        e_empty,
        e_hold
    } state_e;

    state_e                    state;
    logic [addr_width_lp-1:0]  buf_addr;
    logic [mask_width_lp-1:0]  buf_mask;
    logic [width_p-1:0]        buf_data;
    logic [timer_width_lp-1:0] timer;

    logic [width_p-1:0] in_bits;
    logic               hold;
    logic               addr_hit;
    logic               hard_flush;
    logic               flush;
    logic               accept;
    logic               load_ok;

    // Expand the incoming byte enables to a per-bit mask for zeroing and merging.
    always_comb begin
        in_bits = '0;
        for (int i = 0; i < mask_width_lp; i++) begin
            in_bits[i*8 +: 8] = {8{mask_i[i]}};
        end
    end

    // Flush decode and handshake; mask_i and data_i stay off every output path.
    always_comb begin
        hold       = (state == e_hold);
        addr_hit   = (addr_i == buf_addr);
        // Full, timeout and flush_i writes stall the client so a store can't slip past the drain.
        hard_flush = hold & ((&buf_mask) | (timer == timeout_lp) | flush_i);
        // A store to a different address evicts the buffer but is itself accepted.
        flush      = hard_flush | (hold & v_i & ~addr_hit);
        ready_o    = ~hard_flush;
        accept     = v_i & ready_o;
        load_ok    = accept & (|mask_i);
    end

    // Write port shows the buffer only while a write is being issued.
    always_comb begin
        w_v_o    = flush;
        w_mask_o = flush ? buf_mask : '0;
        w_addr_o = flush ? buf_addr : '0;
        w_data_o = flush ? buf_data : '0;
    end

    assign pending_o      = hold;
    assign pending_addr_o = buf_addr;

    // Buffer state machine: load, merge, idle timer and drain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= e_empty;
            buf_addr <= '0;
            buf_mask <= '0;
            buf_data <= '0;
            timer    <= '0;
        end else begin
            case (state)
                e_empty: begin
                    if (load_ok) begin
                        state    <= e_hold;
                        buf_addr <= addr_i;
                        buf_mask <= mask_i;
                        buf_data <= data_i & in_bits;
                        timer    <= '0;
                    end
                end
                e_hold: begin
                    if (flush) begin
                        // Only an address-change flush can carry an accepted store.
                        if (load_ok) begin
                            buf_addr <= addr_i;
                            buf_mask <= mask_i;
                            buf_data <= data_i & in_bits;
                            timer    <= '0;
                        end else begin
                            state <= e_empty;
                        end
                    end else if (accept) begin
                        // Same-address store: later bytes win; a zero mask just restarts the timer.
                        buf_mask <= buf_mask | mask_i;
                        buf_data <= (buf_data & ~in_bits) | (data_i & in_bits);
                        timer    <= '0;
                    end else if (timer != timeout_lp) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= e_empty;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_mem_byte_write_coalescer.sv
module tb_bsg_mem_byte_write_coalescer;

    localparam int W  = 32;
    localparam int AW = 9;
    localparam int MW = 4;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [AW-1:0] addr_i;
    logic [MW-1:0] mask_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          flush_i;
    logic          w_v_o;
    logic [MW-1:0] w_mask_o;
    logic [AW-1:0] w_addr_o;
    logic [W-1:0]  w_data_o;
    logic          pending_o;
    logic [AW-1:0] pending_addr_o;

    bsg_mem_byte_write_coalescer #(
        .width_p  (W),
        .els_p    (512),
        .timeout_p(TO)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .addr_i        (addr_i),
        .mask_i        (mask_i),
        .data_i        (data_i),
        .ready_o       (ready_o),
        .flush_i       (flush_i),
        .w_v_o         (w_v_o),
        .w_mask_o      (w_mask_o),
        .w_addr_o      (w_addr_o),
        .w_data_o      (w_data_o),
        .pending_o     (pending_o),
        .pending_addr_o(pending_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [W-1:0]  data;
        int            cyc;
    } wr_t;

    wr_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [MW-1:0] m,
                             input logic [W-1:0] d, input int c);
        wr_t e;
        e.addr = a;
        e.mask = m;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Scoreboard: every write is matched against the oldest expected write, including its cycle.
    always @(negedge clk_i) begin
        if (w_v_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {55'd0, w_addr_o}, 64'h1ff);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {55'd0, w_addr_o}, {55'd0, e.addr});
                chk("wr_mask", {60'd0, w_mask_o}, {60'd0, e.mask});
                chk("wr_data", {32'd0, w_data_o}, {32'd0, e.data});
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("idle_outputs_zero", {19'd0, w_mask_o, w_addr_o, w_data_o}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Presents one store and holds it until accepted; returns the acceptance cycle.
    task automatic store(input logic [AW-1:0] a, input logic [MW-1:0] m,
                         input logic [W-1:0] d, output int acc);
        acc    = -1;
        v_i    = 1'b1;
        addr_i = a;
        mask_i = m;
        data_i = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (ready_o) acc = cyc;
            step();
            if (acc >= 0) break;
        end
        v_i    = 1'b0;
        addr_i = '0;
        mask_i = '0;
        data_i = '0;
        if (acc < 0) chk("store_accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int a1, a2, cf;
        reset_i = 1'b1;
        v_i     = 1'b0;
        addr_i  = '0;
        mask_i  = '0;
        data_i  = '0;
        flush_i = 1'b0;
        #2;
        chk("rst_w_v", {63'd0, w_v_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_pending", {63'd0, pending_o}, 64'd0);
        chk("rst_pending_addr", {55'd0, pending_addr_o}, 64'd0);
        #10;
        reset_i = 1'b0;
        step();

        // Full-mask store writes the next cycle with ready low, then empties.
        store(9'd5, 4'hF, 32'hDEADBEEF, a1);
        expect_wr(9'd5, 4'hF, 32'hDEADBEEF, a1 + 1);
        @(negedge clk_i);
        chk("full_ready_low", {63'd0, ready_o}, 64'd0);
        chk("full_pending", {63'd0, pending_o}, 64'd1);
        step();
        @(negedge clk_i);
        chk("full_after_ready", {63'd0, ready_o}, 64'd1);
        chk("full_after_pending", {63'd0, pending_o}, 64'd0);
        step();
        idle(2);

        // Merge then timeout; pending held until the write cycle.
        store(9'd3, 4'b0001, 32'h00000011, a1);
        store(9'd3, 4'b0100, 32'h00330000, a2);
        chk("merge_accept_cycle", 64'(a2), 64'(a1 + 1));
        expect_wr(9'd3, 4'b0101, 32'h00330011, a2 + 1 + TO);
        for (int k = 0; k <= TO; k++) begin
            @(negedge clk_i);
            chk("merge_pending", {63'd0, pending_o}, 64'd1);
            step();
        end
        @(negedge clk_i);
        chk("merge_pending_clear", {63'd0, pending_o}, 64'd0);
        step();
        idle(2);

        // Same byte written twice: later data wins.
        store(9'd7, 4'b0001, 32'h00000011, a1);
        store(9'd7, 4'b0001, 32'h00000022, a2);
        expect_wr(9'd7, 4'b0001, 32'h00000022, a2 + 1 + TO);
        idle(TO + 3);

        // Merge that completes the mask writes the next cycle.
        store(9'd6, 4'b0011, 32'h00001234, a1);
        store(9'd6, 4'b1100, 32'hABCD0000, a2);
        expect_wr(9'd6, 4'hF, 32'hABCD1234, a2 + 1);
        idle(3);

        // Address change: old word written in the same cycle the new store is taken.
        store(9'd1, 4'b0011, 32'h0000BEEF, a1);
        expect_wr(9'd1, 4'b0011, 32'h0000BEEF, cyc);
        store(9'd2, 4'b1100, 32'hCAFE0000, a2);
        chk("addr_chg_accept_cycle", 64'(a2), 64'(a1 + 1));
        expect_wr(9'd2, 4'b1100, 32'hCAFE0000, a2 + 1 + TO);
        @(negedge clk_i);
        chk("addr_chg_pending_addr", {55'd0, pending_addr_o}, 64'd2);
        step();
        idle(TO + 3);

        // Back-to-back distinct addresses: one write per cycle, unmasked bytes zeroed.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) expect_wr(9'(10 + i - 1), 4'b0001, 32'(i + 8), cyc);
            store(9'(10 + i), 4'b0001, 32'hFFFFFF00 | 32'(i + 9), a2);
            if (i > 0) chk("b2b_accept_cycle", 64'(a2), 64'(a1 + 1));
            a1 = a2;
        end
        expect_wr(9'd12, 4'b0001, 32'd11, a2 + 1 + TO);
        idle(TO + 3);

        // flush_i collides with a same-address store: write out, store held one cycle, fresh load.
        store(9'd4, 4'b0001, 32'h00000044, a1);
        expect_wr(9'd4, 4'b0001, 32'h00000044, cyc);
        flush_i = 1'b1;
        v_i     = 1'b1;
        addr_i  = 9'd4;
        mask_i  = 4'b0010;
        data_i  = 32'h00005500;
        @(negedge clk_i);
        chk("flush_coll_ready", {63'd0, ready_o}, 64'd0);
        cf = cyc;
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_coll_accept", {63'd0, ready_o}, 64'd1);
        chk("flush_coll_accept_cycle", 64'(cyc), 64'(cf + 1));
        a2 = cyc;
        step();
        v_i    = 1'b0;
        mask_i = '0;
        data_i = '0;
        expect_wr(9'd4, 4'b0010, 32'h00005500, a2 + 1 + TO);
        idle(TO + 3);

        // Asynchronous reset mid-hold discards the buffered word.
        store(9'd9, 4'b0001, 32'h00000099, a1);
        idle(2);
        chk("pre_rst_pending", {63'd0, pending_o}, 64'd1);
        chk("pre_rst_pending_addr", {55'd0, pending_addr_o}, 64'd9);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_w_v", {63'd0, w_v_o}, 64'd0);
        chk("async_rst_ready", {63'd0, ready_o}, 64'd1);
        chk("async_rst_pending", {63'd0, pending_o}, 64'd0);
        chk("async_rst_pending_addr", {55'd0, pending_addr_o}, 64'd0);
        #10;
        reset_i = 1'b0;
        step();
        idle(TO + 6);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
